// File: rtl/vga_axi_lite_slave_mem.sv
// AXI-Lite read-only frame-buffer slave with a local word-write fill port. VGA_AXI_SLAVE_RANGE_CHK_EN enables the SLVERR range check.
// Latency: AR accepted -> one FETCH cycle -> RESP; one transaction at a time, R holds until s_rrdy_i.
module vga_axi_lite_slave_mem #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_araddr_i,
    input  logic [2:0]                    s_arprot_i,
    input  logic                          s_arvalid_i,
    output logic                          s_arrdy_o,
    output logic [AXI_DATA_WIDTH-1:0]     s_rdata_o,
    output logic [1:0]                    s_rresp_o,
    output logic                          s_rvalid_o,
    input  logic                          s_rrdy_i,
    input  logic                          wr_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  wr_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wr_data_i
);
    localparam int OFF_W = $clog2(AXI_DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      init_q;
    logic [IDX_W-1:0]          addr_q, addr_d;
    logic                      oor_q, oor_d;
    logic                      rd_en;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [AXI_DATA_WIDTH-1:0] ram_q;
    logic [AXI_ADDR_WIDTH-1:0] word_full;
    logic                      unused_ok;

    assign word_full = s_araddr_i >> OFF_W;
    assign unused_ok = ^{s_arprot_i, word_full[AXI_ADDR_WIDTH-1:IDX_W]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        oor_d      = oor_q;
        s_arrdy_o  = 1'b0;
        s_rvalid_o = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                // init_q keeps AR closed until the first edge after reset release
                s_arrdy_o = init_q;
                if (init_q && s_arvalid_i) begin
                    addr_d  = word_full[IDX_W-1:0];
`ifdef VGA_AXI_SLAVE_RANGE_CHK_EN
                    oor_d   = |word_full[AXI_ADDR_WIDTH-1:IDX_W];
`else
                    oor_d   = 1'b0;
`endif
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                s_rvalid_o = 1'b1;
                if (s_rrdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            addr_q  <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            addr_q  <= addr_d;
            oor_q   <= oor_d;
        end
    end

    // Non-blocking write and read in one block gives read-first on a collision
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en && !oor_q) begin
            ram_q <= mem[addr_q];
        end
    end

    assign s_rdata_o = (s_rvalid_o && !oor_q) ? ram_q : '0;
    assign s_rresp_o = (s_rvalid_o && oor_q) ? 2'b10 : 2'b00;

endmodule
